// File: rtl/quad_enc_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : quad_enc_bank_if
//  Purpose  : Polled read port of the quadrature encoder bank. The core
//             (master) issues a one-cycle read strobe with an address. The
//             bank (slave) answers one cycle later with a qualified data word.
//  Signals  : rd_en    master->slave  read strobe, one cycle
//             rd_sel   master->slave  read address (4 bits)
//             rd_data  slave->master  read data (16 bits), held until next read
//             rd_valid slave->master  one-cycle pulse qualifying rd_data
//  Revision : 1.0  initial release
// ============================================================================
interface quad_enc_bank_if;
    logic        rd_en;
    logic [3:0]  rd_sel;
    logic [15:0] rd_data;
    logic        rd_valid;

    modport master (
        output rd_en,
        output rd_sel,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  rd_en,
        input  rd_sel,
        output rd_data,
        output rd_valid
    );
endinterface : quad_enc_bank_if
`default_nettype wire

// File: rtl/quad_enc_bank.sv
`default_nettype none
// ============================================================================
//  Module   : quad_enc_bank
//  Purpose  : Multi-channel rotary encoder front end. Each channel has a 2-flop
//             synchroniser, a FILT_LEN-sample agreement filter on A and B, a
//             rising-edge-of-A step decoder (B selects the direction) and a
//             bounded position counter that saturates or wraps at CH_MAX.
//             Counts are exported flat. A registered read port returns
//             {moved, count} per channel and clears the sticky moved flag.
//  Optional : `define ENC_VELOCITY_EN adds per-channel signed step accumulators.
//             They are latched into velocity registers every VEL_WINDOW cycles
//             and are readable at rd_sel = 8+i.
//  Ports    : clk         system clock
//             rstBtn      asynchronous active-low reset
//             enc_a/enc_b encoder phases, one bit per channel, asynchronous
//             clr         synchronous per-channel clear of the count
//             count_flat  live counts, channel 0 in the LSBs
//             moved       sticky "stepped since last read" flags
//             rd          read port (quad_enc_bank_if.slave)
//  Revision : 1.0  initial release
// ============================================================================
module quad_enc_bank #(
    parameter int                      NUM_CH     = 3,
    parameter int                      CNT_W      = 8,
    parameter logic [NUM_CH*CNT_W-1:0] CH_MAX     = {8'd255, 8'd119, 8'd159},
    parameter int                      WRAP       = 0,
    parameter int                      FILT_LEN   = 4,
    parameter int                      VEL_WINDOW = 1000000
) (
    input  wire logic                    clk,
    input  wire logic                    rstBtn,
    input  wire logic [NUM_CH-1:0]       enc_a,
    input  wire logic [NUM_CH-1:0]       enc_b,
    input  wire logic [NUM_CH-1:0]       clr,
    output logic      [NUM_CH*CNT_W-1:0] count_flat,
    output logic      [NUM_CH-1:0]       moved,
    quad_enc_bank_if.slave               rd
);

    // A bank built outside its legal range never answers reads, so a bad
    // integration shows up at the first poll.
    localparam logic c_CFG_OK = (NUM_CH >= 1) && (NUM_CH <= 8) &&
                                (CNT_W >= 2) && (CNT_W <= 15) &&
                                (FILT_LEN >= 2) && (FILT_LEN <= 16) &&
                                (VEL_WINDOW >= 1);

    // Edges after reset release until every filter window holds real pin
    // samples: 2 synchroniser stages plus FILT_LEN-1 history stages.
    localparam int c_WARM_W = 5;
    localparam logic [c_WARM_W-1:0] c_WARM = c_WARM_W'(FILT_LEN + 1);

    logic [c_WARM_W-1:0] r_warm;
    logic                w_warm;
    logic [NUM_CH-1:0]   w_rd_clr;
    logic [15:0]         w_rd_word;
    logic [15:0]         r_rd_data;
    logic                r_rd_valid;

    assign w_warm = (r_warm == c_WARM);

    always_ff @(posedge clk or negedge rstBtn) begin
        if (!rstBtn) begin
            r_warm <= '0;
        end else if (!w_warm) begin
            r_warm <= r_warm + c_WARM_W'(1);
        end
    end

`ifdef ENC_VELOCITY_EN
    localparam int c_WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;

    logic [c_WIN_W-1:0]    r_win;
    logic                  w_win_tick;
    logic [NUM_CH*8-1:0]   w_vel_flat;

    assign w_win_tick = (r_win == c_WIN_W'(VEL_WINDOW - 1));

    always_ff @(posedge clk or negedge rstBtn) begin
        if (!rstBtn) begin
            r_win <= '0;
        end else if (w_win_tick) begin
            r_win <= '0;
        end else begin
            r_win <= r_win + c_WIN_W'(1);
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]          r_sync_a, r_sync_b;
        logic [FILT_LEN-2:0] r_hist_a, r_hist_b;
        logic [FILT_LEN-1:0] w_win_a, w_win_b;
        logic                w_all1_a, w_all0_a, w_all1_b, w_all0_b;
        logic                r_fa, r_fa_d, r_fb, r_armed;
        logic                w_step, w_up, w_dn;
        logic [CNT_W-1:0]    w_max, r_cnt, w_cnt_nxt;
        logic                w_moves, r_moved;

        // The newest synchronised sample joins the history, so a level is
        // accepted on the same edge its FILT_LEN-th agreeing sample arrives.
        assign w_win_a  = {r_hist_a, r_sync_a[1]};
        assign w_win_b  = {r_hist_b, r_sync_b[1]};
        assign w_all1_a = &w_win_a;
        assign w_all0_a = ~|w_win_a;
        assign w_all1_b = &w_win_b;
        assign w_all0_b = ~|w_win_b;

        always_ff @(posedge clk or negedge rstBtn) begin
            if (!rstBtn) begin
                r_sync_a <= '0;
                r_sync_b <= '0;
                r_hist_a <= '0;
                r_hist_b <= '0;
                r_fa     <= 1'b0;
                r_fa_d   <= 1'b0;
                r_fb     <= 1'b0;
                r_armed  <= 1'b0;
            end else begin
                r_sync_a <= {r_sync_a[0], enc_a[i]};
                r_sync_b <= {r_sync_b[0], enc_b[i]};
                r_hist_a <= w_win_a[FILT_LEN-2:0];
                r_hist_b <= w_win_b[FILT_LEN-2:0];
                if (w_all1_b) begin
                    r_fb <= 1'b1;
                end else if (w_all0_b) begin
                    r_fb <= 1'b0;
                end
                // The first settled A level after reset is taken as the
                // baseline: both the level and its delayed copy load it, so
                // a pin that is already high does not produce a step.
                if (!r_armed) begin
                    if (w_warm && (w_all1_a || w_all0_a)) begin
                        r_armed <= 1'b1;
                        r_fa    <= w_all1_a;
                        r_fa_d  <= w_all1_a;
                    end
                end else begin
                    if (w_all1_a) begin
                        r_fa <= 1'b1;
                    end else if (w_all0_a) begin
                        r_fa <= 1'b0;
                    end
                    r_fa_d <= r_fa;
                end
            end
        end

        assign w_step = r_armed & r_fa & ~r_fa_d;
        assign w_up   = w_step & ~r_fb;
        assign w_dn   = w_step &  r_fb;
        assign w_max  = CH_MAX[i*CNT_W +: CNT_W];

        always_comb begin
            w_cnt_nxt = r_cnt;
            w_moves   = 1'b0;
            if (w_up) begin
                if (r_cnt == w_max) begin
                    if (WRAP != 0) begin
                        w_cnt_nxt = '0;
                        w_moves   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_moves   = 1'b1;
                end
            end else if (w_dn) begin
                if (r_cnt == '0) begin
                    if (WRAP != 0) begin
                        w_cnt_nxt = w_max;
                        w_moves   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_moves   = 1'b1;
                end
            end
        end

        // A step overridden by clr is not a move. A real move on the edge
        // that reads the channel keeps the flag set.
        always_ff @(posedge clk or negedge rstBtn) begin
            if (!rstBtn) begin
                r_cnt   <= '0;
                r_moved <= 1'b0;
            end else begin
                r_cnt <= clr[i] ? '0 : w_cnt_nxt;
                if (w_moves && !clr[i]) begin
                    r_moved <= 1'b1;
                end else if (w_rd_clr[i]) begin
                    r_moved <= 1'b0;
                end
            end
        end

        assign count_flat[i*CNT_W +: CNT_W] = r_cnt;
        assign moved[i]                     = r_moved;

`ifdef ENC_VELOCITY_EN
        logic signed [7:0] r_acc, r_vel, w_acc_nxt;

        // Raw steps are counted, including those the position counter blocks.
        always_comb begin
            w_acc_nxt = r_acc;
            if (w_up && (r_acc != 8'sd127)) begin
                w_acc_nxt = r_acc + 8'sd1;
            end else if (w_dn && (r_acc != -8'sd127)) begin
                w_acc_nxt = r_acc - 8'sd1;
            end
        end

        always_ff @(posedge clk or negedge rstBtn) begin
            if (!rstBtn) begin
                r_acc <= '0;
                r_vel <= '0;
            end else if (w_win_tick) begin
                r_vel <= w_acc_nxt;
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_nxt;
            end
        end

        assign w_vel_flat[i*8 +: 8] = r_vel;
`endif
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        w_rd_word = '0;
        w_rd_clr  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd.rd_sel == 4'(k)) begin
                w_rd_word[CNT_W-1:0] = count_flat[k*CNT_W +: CNT_W];
                w_rd_word[15]        = moved[k];
                w_rd_clr[k]          = rd.rd_en;
            end
`ifdef ENC_VELOCITY_EN
            if (rd.rd_sel == 4'(8 + k)) begin
                w_rd_word = {{8{w_vel_flat[k*8+7]}}, w_vel_flat[k*8 +: 8]};
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rstBtn) begin
        if (!rstBtn) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd.rd_en & c_CFG_OK;
            if (rd.rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd.rd_data  = r_rd_data;
    assign rd.rd_valid = r_rd_valid;

endmodule : quad_enc_bank
`default_nettype wire

// File: tb/tb_quad_enc_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quad_enc_bank
//  Purpose  : Directed self-checking bench for quad_enc_bank. u_dut0 is the
//             saturating bank (FILT_LEN=4), u_dut1 the wrapping bank
//             (FILT_LEN=2) that also carries the velocity checks when
//             ENC_VELOCITY_EN is defined. Read results are checked through
//             per-DUT expectation queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_quad_enc_bank;

    logic        clk = 1'b0;
    logic        rstBtn;
    logic [2:0]  a0, b0, c0, a1, b1, c1;
    logic [23:0] cnt0, cnt1;
    logic [2:0]  mv0, mv1;
    int          total = 0;
    int          bad   = 0;
    int          cyc;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    quad_enc_bank_if rif0 ();
    quad_enc_bank_if rif1 ();

    always #5 clk = ~clk;

    quad_enc_bank #(
        .NUM_CH(3), .CNT_W(8), .CH_MAX({8'd255, 8'd119, 8'd159}),
        .WRAP(0), .FILT_LEN(4), .VEL_WINDOW(1000)
    ) u_dut0 (
        .clk(clk), .rstBtn(rstBtn), .enc_a(a0), .enc_b(b0), .clr(c0),
        .count_flat(cnt0), .moved(mv0), .rd(rif0)
    );

    quad_enc_bank #(
        .NUM_CH(3), .CNT_W(8), .CH_MAX({8'd255, 8'd119, 8'd159}),
        .WRAP(1), .FILT_LEN(2), .VEL_WINDOW(1000)
    ) u_dut1 (
        .clk(clk), .rstBtn(rstBtn), .enc_a(a1), .enc_b(b1), .clr(c1),
        .count_flat(cnt1), .moved(mv1), .rd(rif1)
    );

    // Cycles since reset release, used to line up with the velocity window.
    always @(posedge clk or negedge rstBtn) begin
        if (!rstBtn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One detent: set B for the direction, A low for 'half' cycles, then high.
    task automatic step(input int d, input int ch, input bit ccw, input int half);
        if (d == 0) b0[ch] = ccw; else b1[ch] = ccw;
        tick(half);
        if (d == 0) a0[ch] = 1'b1; else a1[ch] = 1'b1;
        tick(half);
        if (d == 0) a0[ch] = 1'b0; else a1[ch] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [3:0] sel, input logic [15:0] exp);
        if (d == 0) begin
            rif0.rd_en = 1'b1; rif0.rd_sel = sel; q0.push_back(exp);
        end else begin
            rif1.rd_en = 1'b1; rif1.rd_sel = sel; q1.push_back(exp);
        end
        tick(1);
        rif0.rd_en = 1'b0;
        rif1.rd_en = 1'b0;
    endtask

    task automatic drain();
        tick(3);
        chk("rd0_all_answered", 32'(q0.size()), 32'd0);
        chk("rd1_all_answered", 32'(q1.size()), 32'd0);
    endtask

    task automatic wait_off(input int off);
        int n = 0;
        while (((cyc % 1000) != off) && (n < 3000)) begin
            tick(1);
            n++;
        end
        chk("win_align", 32'(cyc % 1000), 32'(off));
    endtask

    // Scoreboard: every rd_valid pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (rif0.rd_valid === 1'b1) begin
            if (q0.size() == 0) chk("rd0_pending", 32'(q0.size()), 32'd1);
            else                chk("rd0_data", 32'(rif0.rd_data), 32'(q0.pop_front()));
        end
        if (rif1.rd_valid === 1'b1) begin
            if (q1.size() == 0) chk("rd1_pending", 32'(q1.size()), 32'd1);
            else                chk("rd1_data", 32'(rif1.rd_data), 32'(q1.pop_front()));
        end
    end

    initial begin
        rstBtn = 1'b0;
        a0 = '1; b0 = '1; c0 = '0;
        a1 = '1; b1 = '1; c1 = '0;
        rif0.rd_en = 1'b0; rif0.rd_sel = '0;
        rif1.rd_en = 1'b0; rif1.rd_sel = '0;
        tick(5);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_mv0", 32'(mv0), 32'd0);
        chk("rst_valid0", 32'(rif0.rd_valid), 32'd0);
        chk("rst_data0", 32'(rif0.rd_data), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);

        // Release with all pins high: no step may appear.
        @(negedge clk) rstBtn = 1'b1;
        tick(100);
        chk("rel_cnt0", 32'(cnt0), 32'd0);
        chk("rel_mv0", 32'(mv0), 32'd0);
        chk("rel_cnt1", 32'(cnt1), 32'd0);
        chk("rel_mv1", 32'(mv1), 32'd0);
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(20);
        chk("fall_cnt0", 32'(cnt0), 32'd0);
        chk("fall_cnt1", 32'(cnt1), 32'd0);

        // Saturating channel 0: 170 up against limit 159, then 200 down.
        repeat (170) step(0, 0, 1'b0, 6);
        tick(12);
        chk("sat_hi", 32'(cnt0[7:0]), 32'd159);
        chk("sat_hi_mv", 32'(mv0[0]), 32'd1);
        chk("sat_others", 32'(cnt0[23:8]), 32'd0);
        repeat (200) step(0, 0, 1'b1, 6);
        tick(12);
        chk("sat_lo", 32'(cnt0[7:0]), 32'd0);
        rd(0, 4'd0, 16'h8000);
        drain();
        chk("rd_clr_mv0", 32'(mv0[0]), 32'd0);
        chk("rd_hold", 32'(rif0.rd_data), 32'h8000);

        // Wrapping bank, channel 1 (limit 119).
        step(1, 1, 1'b1, 4);
        tick(8);
        chk("wrap_dn", 32'(cnt1[15:8]), 32'd119);
        chk("wrap_mv", 32'(mv1[1]), 32'd1);
        step(1, 1, 1'b0, 4);
        tick(8);
        chk("wrap_up", 32'(cnt1[15:8]), 32'd0);

        // Glitch of FILT_LEN-1 cycles on channel 2, then a clean edge.
        a0[2] = 1'b1; tick(3); a0[2] = 1'b0;
        tick(20);
        chk("glitch", 32'(cnt0[23:16]), 32'd0);
        a0[2] = 1'b1;
        tick(6);
        chk("lat_early", 32'(cnt0[23:16]), 32'd0);
        tick(1);
        chk("lat_exact", 32'(cnt0[23:16]), 32'd1);
        a0[2] = 1'b0;
        tick(12);

        // Step and read of channel 0 on the same edge.
        step(0, 0, 1'b0, 6);
        tick(12);
        chk("pre_cnt0", 32'(cnt0[7:0]), 32'd1);
        a0[0] = 1'b1;
        tick(6);
        rif0.rd_en = 1'b1; rif0.rd_sel = 4'd0; q0.push_back(16'h8001);
        tick(1);
        rif0.rd_en = 1'b0;
        chk("coll_cnt0", 32'(cnt0[7:0]), 32'd2);
        chk("coll_mv0", 32'(mv0[0]), 32'd1);
        a0[0] = 1'b0;
        drain();

        // clr beats a simultaneous step on channel 1.
        step(0, 1, 1'b0, 6);
        tick(12);
        chk("pre_cnt1", 32'(cnt0[15:8]), 32'd1);
        a0[1] = 1'b1;
        tick(6);
        c0[1] = 1'b1;
        tick(1);
        c0[1] = 1'b0;
        chk("clr_step", 32'(cnt0[15:8]), 32'd0);
        a0[1] = 1'b0;
        tick(12);
        chk("clr_hold", 32'(cnt0[15:8]), 32'd0);

        // Back-to-back reads, including an unmapped address.
        rif0.rd_en = 1'b1; rif0.rd_sel = 4'd1; q0.push_back(16'h8000);
        tick(1);
        rif0.rd_sel = 4'd3; q0.push_back(16'h0000);
        tick(1);
        rif0.rd_sel = 4'd2; q0.push_back(16'h8001);
        tick(1);
        rif0.rd_en = 1'b0;
        drain();
        chk("b2b_mv0", 32'(mv0), 32'd1);
        rd(0, 4'd15, 16'h0000);
        drain();

`ifdef ENC_VELOCITY_EN
        wait_off(10);
        repeat (5) step(1, 0, 1'b0, 2);
        repeat (2) step(1, 0, 1'b1, 2);
        wait_off(10);
        rd(1, 4'd8, 16'h0003);
        repeat (150) step(1, 0, 1'b0, 2);
        wait_off(10);
        rd(1, 4'd8, 16'h007F);
        drain();
`else
        rd(0, 4'd8, 16'h0000);
        rd(1, 4'd8, 16'h0000);
        drain();
`endif

        // Asynchronous reset in the middle of a pulse on channel 0.
        chk("pre_async", 32'(cnt0[7:0]), 32'd2);
        a0[0] = 1'b1; b0[0] = 1'b0;
        tick(3);
        #2;
        rstBtn = 1'b0;
        #1;
        chk("async_cnt0", 32'(cnt0), 32'd0);
        chk("async_mv0", 32'(mv0), 32'd0);
        chk("async_data0", 32'(rif0.rd_data), 32'd0);
        chk("async_cnt1", 32'(cnt1), 32'd0);
        a0[0] = 1'b0;
        tick(3);
        @(negedge clk) rstBtn = 1'b1;
        tick(20);
        chk("post_async", 32'(cnt0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_quad_enc_bank
`default_nettype wire
